xor_update_issue: RTL and testbench

Request-side issue stage that sits directly upstream of the banked XOR-hash table (URAM banks with a fixed 5-cycle internal write pipeline and no internal forwarding). It accepts per-bank XOR update requests, issues the table read, XORs the returned bank words with the request operand, and drives the table's write port with correct index/data alignment. Because the table does not forward its own writes, this block forwards in-flight results itself. After reset it runs a zero-fill sweep over every index.

---
 rtl/xor_hash_pkg.sv | 34 +++
 rtl/fwd_history.sv | 85 ++++++++
 rtl/xor_update_issue.sv | 205 ++++++++++++++++++++
 tb/tb_xor_update_issue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_hash_pkg.sv
// -----------------------------------------------------------------------------
// xor_hash_pkg
//   Shared constants, types and helpers for the XOR-hash table issue stage.
//
//   TABLE_WR_DELAY : cycles from the table's index phase to its commit
//   XOR_ALIGN      : cycles by which the table's data phase trails its index phase
//   fwd_depth()    : number of older ops whose commit a younger read cannot see
//   issue_state_e  : issue-stage FSM states
//   op_flags_t     : per-op control flags carried down the issue pipeline
// -----------------------------------------------------------------------------
package xor_hash_pkg;

  localparam int TABLE_WR_DELAY = 5;
  localparam int XOR_ALIGN      = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } issue_state_e;

  // kill forces the result to zero and ignores read data (zero-fill sweep).
  typedef struct packed {
    logic valid;
    logic kill;
  } op_flags_t;

  // An op accepted at t reads the table at t+1; an older op accepted at t0
  // becomes visible to reads from t0+L+TABLE_WR_DELAY+1 on. Older ops at ages
  // 1 .. L+TABLE_WR_DELAY-1 are therefore invisible and must be forwarded.
  function automatic int fwd_depth(input int rd_latency);
    return rd_latency + TABLE_WR_DELAY - 1;
  endfunction

endpackage

// File: rtl/fwd_history.sv
// -----------------------------------------------------------------------------
// fwd_history
//   Shift register of recently computed results plus a per-bank
//   youngest-match priority mux. Entry 0 is the youngest op.
//
//   clk, rst_n     : clock, synchronous active-low reset (clears valids)
//   push_*         : result entering the history this cycle (valid=0 = bubble)
//   lookup_index   : index of the op currently computing its result
//   hit[b]         : bank b has a matching in-flight result
//   fwd_word       : per-bank forwarded word, bank b at [b*DATA_WIDTH +: DATA_WIDTH]
// -----------------------------------------------------------------------------
module fwd_history #(
  parameter int NUM_MUL     = 4,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64,
  parameter int DEPTH       = 6
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_valid,
  input  logic [INDEX_WIDTH-1:0]        push_index,
  input  logic [NUM_MUL-1:0]            push_mask,
  input  logic [NUM_MUL*DATA_WIDTH-1:0] push_res,
  input  logic [INDEX_WIDTH-1:0]        lookup_index,
  output logic [NUM_MUL-1:0]            hit,
  output logic [NUM_MUL*DATA_WIDTH-1:0] fwd_word
);

  localparam int VEC_W = NUM_MUL * DATA_WIDTH;

  logic [DEPTH-1:0]       valid_q, valid_d;
  logic [INDEX_WIDTH-1:0] index_q [DEPTH];
  logic [INDEX_WIDTH-1:0] index_d [DEPTH];
  logic [NUM_MUL-1:0]     mask_q  [DEPTH];
  logic [NUM_MUL-1:0]     mask_d  [DEPTH];
  logic [VEC_W-1:0]       res_q   [DEPTH];
  logic [VEC_W-1:0]       res_d   [DEPTH];

  always_comb begin
    valid_d    = {valid_q[DEPTH-2:0], push_valid};
    index_d[0] = push_index;
    mask_d[0]  = push_mask;
    res_d[0]   = push_res;
    for (int k = 1; k < DEPTH; k++) begin
      index_d[k] = index_q[k-1];
      mask_d[k]  = mask_q[k-1];
      res_d[k]   = res_q[k-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the shift.
  always_ff @(posedge clk) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // NOTE: the payload is deliberately not reset: it is only consumed when the
  // matching valid bit is set, and leaving it out keeps the reset fan-out small.
  always_ff @(posedge clk) begin
    for (int k = 0; k < DEPTH; k++) begin
      index_q[k] <= index_d[k];
      mask_q[k]  <= mask_d[k];
      res_q[k]   <= res_d[k];
    end
  end

  // Scan oldest to youngest so the youngest match overrides; each bank picks
  // its own entry, since ops with different masks touch different banks.
  // NOTE: every output gets a default before the conditional updates, otherwise
  // the no-match path would infer a latch.
  always_comb begin
    hit      = '0;
    fwd_word = '0;
    for (int b = 0; b < NUM_MUL; b++) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (valid_q[k] && (index_q[k] == lookup_index) && mask_q[k][b]) begin
          hit[b] = 1'b1;
          fwd_word[b*DATA_WIDTH +: DATA_WIDTH] = res_q[k][b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/xor_update_issue.sv
// -----------------------------------------------------------------------------
// xor_update_issue
//   Issue stage in front of the banked XOR-hash table. Reads the table, XORs
//   the returned bank words with the request operand and drives the table's
//   two-phase write port. The table does not forward its own writes, so
//   results still in its write pipeline are forwarded from a local history.
//   After reset every index is swept to zero before requests are accepted.
//
//   clk, reset           : clock, synchronous active-low reset
//   req_valid/ready      : request handshake (ready only after the sweep)
//   req_index/mask/data  : table index, banks to update, XOR operand
//   rd_index             : table read address (holds during bubbles)
//   rd_out_update        : table read data, RD_LATENCY cycles after rd_index
//   write_reg_0_valid    : table write, index phase
//   write_reg_0_index    : table write index, index phase
//   write_reg_11_xor     : table write data, data phase
//   arbiter_result       : per-bank write enable, data phase
//   init_done            : zero sweep complete
// -----------------------------------------------------------------------------
module xor_update_issue
  import xor_hash_pkg::*;
#(
  parameter int NUM_MUL     = 4,
  parameter int INDEX_WIDTH = 12,
  parameter int DATA_WIDTH  = 64,
  parameter int RD_LATENCY  = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [INDEX_WIDTH-1:0]        req_index,
  input  logic [NUM_MUL-1:0]            req_mask,
  input  logic [NUM_MUL*DATA_WIDTH-1:0] req_data,
  output logic [INDEX_WIDTH-1:0]        rd_index,
  input  logic [NUM_MUL*DATA_WIDTH-1:0] rd_out_update,
  output logic                          write_reg_0_valid,
  output logic [INDEX_WIDTH-1:0]        write_reg_0_index,
  output logic [NUM_MUL*DATA_WIDTH-1:0] write_reg_11_xor,
  output logic [NUM_MUL-1:0]            arbiter_result,
  output logic                          init_done
);

  localparam int VEC_W = NUM_MUL * DATA_WIDTH;
  // pipe_q[k] holds the op accepted k+1 cycles ago.
  localparam int WR_STAGE  = RD_LATENCY - 1;              // index phase at t+L
  localparam int CMP_STAGE = RD_LATENCY + XOR_ALIGN - 2;  // read data at t+1+L
  localparam int NUM_STAGE = CMP_STAGE + 1;
  localparam int FWD_DEPTH = fwd_depth(RD_LATENCY);

  typedef struct packed {
    op_flags_t              flags;
    logic [INDEX_WIDTH-1:0] index;
    logic [NUM_MUL-1:0]     mask;
    logic [VEC_W-1:0]       data;
  } op_t;

  // ---------------------------------------------------------------------------
  // Sweep / run FSM
  // ---------------------------------------------------------------------------
  issue_state_e           state_q;
  logic [INDEX_WIDTH-1:0] sweep_cnt_q;
  logic                   req_ready_q;
  logic                   init_done_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_INIT;
      sweep_cnt_q <= '0;
      req_ready_q <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          sweep_cnt_q <= sweep_cnt_q + INDEX_WIDTH'(1);
          if (&sweep_cnt_q) begin
            state_q     <= ST_RUN;
            req_ready_q <= 1'b1;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
        end
        default: begin
          state_q <= ST_INIT;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign init_done = init_done_q;

  // ---------------------------------------------------------------------------
  // Op injection: sweep ops during INIT, accepted requests or bubbles in RUN
  // ---------------------------------------------------------------------------
  op_t new_op;

  always_comb begin
    new_op = '0;
    if (state_q == ST_INIT) begin
      new_op.flags.valid = 1'b1;
      new_op.flags.kill  = 1'b1;
      new_op.index       = sweep_cnt_q;
      new_op.mask        = '1;
    end else if (req_valid && req_ready_q) begin
      new_op.flags.valid = 1'b1;
      new_op.index       = req_index;
      new_op.mask        = req_mask;
      new_op.data        = req_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Op pipeline and read address
  // ---------------------------------------------------------------------------
  op_t                    pipe_q [NUM_STAGE];
  op_t                    pipe_d [NUM_STAGE];
  logic [INDEX_WIDTH-1:0] rd_index_q, rd_index_d;

  always_comb begin
    pipe_d[0] = new_op;
    for (int k = 1; k < NUM_STAGE; k++) pipe_d[k] = pipe_q[k-1];
    rd_index_d = new_op.flags.valid ? new_op.index : rd_index_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < NUM_STAGE; k++) pipe_q[k] <= '0;
      rd_index_q <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGE; k++) pipe_q[k] <= pipe_d[k];
      rd_index_q <= rd_index_d;
    end
  end

  assign rd_index          = rd_index_q;
  assign write_reg_0_valid = pipe_q[WR_STAGE].flags.valid;
  assign write_reg_0_index = pipe_q[WR_STAGE].index;

  // ---------------------------------------------------------------------------
  // Result computation with forwarding
  // ---------------------------------------------------------------------------
  op_t                cmp_op;
  logic [NUM_MUL-1:0] fwd_hit;
  logic [VEC_W-1:0]   fwd_word;
  logic [VEC_W-1:0]   xor_d, xor_q;
  logic [NUM_MUL-1:0] arb_d, arb_q;

  assign cmp_op = pipe_q[CMP_STAGE];

  always_comb begin
    logic [DATA_WIDTH-1:0] base;
    base  = '0;
    xor_d = '0;
    for (int b = 0; b < NUM_MUL; b++) begin
      base = fwd_hit[b] ? fwd_word[b*DATA_WIDTH +: DATA_WIDTH]
                        : rd_out_update[b*DATA_WIDTH +: DATA_WIDTH];
      // Unmasked banks pass the current word through so the history entry
      // always carries the full, up-to-date word for every bank.
      if (cmp_op.mask[b])
        xor_d[b*DATA_WIDTH +: DATA_WIDTH] = cmp_op.flags.kill ? '0
                                          : base ^ cmp_op.data[b*DATA_WIDTH +: DATA_WIDTH];
      else
        xor_d[b*DATA_WIDTH +: DATA_WIDTH] = base;
    end
    if (!cmp_op.flags.valid) xor_d = '0;
    arb_d = cmp_op.flags.valid ? cmp_op.mask : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      xor_q <= '0;
      arb_q <= '0;
    end else begin
      xor_q <= xor_d;
      arb_q <= arb_d;
    end
  end

  assign write_reg_11_xor = xor_q;
  assign arbiter_result   = arb_q;

  // The history is fed with the result register's next value, so its entry 0
  // always mirrors the result register and entries 0..FWD_DEPTH-1 hold ages
  // 1..FWD_DEPTH relative to the op now computing.
  fwd_history #(
    .NUM_MUL     (NUM_MUL),
    .INDEX_WIDTH (INDEX_WIDTH),
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH       (FWD_DEPTH)
  ) u_fwd_history (
    .clk          (clk),
    .rst_n        (reset),
    .push_valid   (cmp_op.flags.valid),
    .push_index   (cmp_op.index),
    .push_mask    (cmp_op.mask),
    .push_res     (xor_d),
    .lookup_index (cmp_op.index),
    .hit          (fwd_hit),
    .fwd_word     (fwd_word)
  );

endmodule

// File: tb/tb_xor_update_issue.sv
// -----------------------------------------------------------------------------
// tb_xor_update_issue
//   Bench for xor_update_issue with a behavioural table (L-cycle read,
//   5-cycle write commit, no forwarding) and an in-order scoreboard of
//   expected data-phase writes.
// -----------------------------------------------------------------------------
module tb_xor_update_issue;

  localparam int NM   = 4;
  localparam int IW   = 4;
  localparam int DW   = 64;
  localparam int L    = 2;
  localparam int VW   = NM * DW;
  localparam int NIDX = 1 << IW;
  localparam int DATA_LAT   = L + 2;  // acceptance to data phase
  localparam int COMMIT_LAG = 3;      // data phase to end-of-cycle commit

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [IW-1:0] req_index = '0;
  logic [NM-1:0] req_mask = '0;
  logic [VW-1:0] req_data = '0;
  logic [IW-1:0] rd_index;
  logic [VW-1:0] rd_out_update = '0;
  logic          write_reg_0_valid;
  logic [IW-1:0] write_reg_0_index;
  logic [VW-1:0] write_reg_11_xor;
  logic [NM-1:0] arbiter_result;
  logic          init_done;

  xor_update_issue #(
    .NUM_MUL     (NM),
    .INDEX_WIDTH (IW),
    .DATA_WIDTH  (DW),
    .RD_LATENCY  (L)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_index         (req_index),
    .req_mask          (req_mask),
    .req_data          (req_data),
    .rd_index          (rd_index),
    .rd_out_update     (rd_out_update),
    .write_reg_0_valid (write_reg_0_valid),
    .write_reg_0_index (write_reg_0_index),
    .write_reg_11_xor  (write_reg_11_xor),
    .arbiter_result    (arbiter_result),
    .init_done         (init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [IW-1:0] idx;
    logic [NM-1:0] mask;
    logic [VW-1:0] data;
  } exp_t;

  typedef struct {
    int            when;
    logic [IW-1:0] idx;
    logic [NM-1:0] mask;
    logic [VW-1:0] data;
  } wr_t;

  exp_t          sb[$];
  wr_t           pend[$];
  logic [VW-1:0] tbl     [NIDX];  // physical table contents
  logic [VW-1:0] ref_tbl [NIDX];  // architectural value after all issued ops
  logic [VW-1:0] rp      [L];     // table read pipeline
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_bad = 0;

  // Outputs sampled at the falling edge, consumed by the table at the next rise.
  logic [IW-1:0] s_rd_index = '0;
  logic [NM-1:0] s_arb = '0;
  logic [VW-1:0] s_xor = '0;
  logic [IW-1:0] s_didx = '0;
  logic [IW-1:0] w_idx [2] = '{'0, '0};
  logic          w_v   [2] = '{1'b0, 1'b0};

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Behavioural table: capture the read before this edge's commits land.
  initial begin
    for (int k = 0; k < L; k++) rp[k] = '0;
    forever begin
      @(posedge clk);
      for (int k = L - 1; k > 0; k--) rp[k] = rp[k-1];
      rp[0] = tbl[s_rd_index];
      rd_out_update <= rp[L-1];
      while (pend.size() > 0 && pend[0].when == cyc) begin
        wr_t w;
        w = pend.pop_front();
        for (int b = 0; b < NM; b++)
          if (w.mask[b]) tbl[w.idx][b*DW +: DW] = w.data[b*DW +: DW];
      end
      if (s_arb != '0) pend.push_back('{cyc + COMMIT_LAG, s_didx, s_arb, s_xor});
      cyc++;
    end
  end

  // Output monitor and scoreboard.
  initial begin
    forever begin
      logic [IW-1:0] d_idx;
      logic          d_v;
      exp_t          e;
      @(negedge clk);
      d_idx    = w_idx[1];
      d_v      = w_v[1];
      w_idx[1] = w_idx[0];
      w_v[1]   = w_v[0];
      w_idx[0] = write_reg_0_index;
      w_v[0]   = write_reg_0_valid;
      s_rd_index = rd_index;
      s_arb      = arbiter_result;
      s_xor      = write_reg_11_xor;
      s_didx     = d_idx;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("missed_data_phase", VW'(cyc), VW'(sb[0].cyc));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check("wr_mask", VW'(s_arb), VW'(e.mask));
        check("wr_data", s_xor, e.data);
        check("wr_index", VW'(d_idx), VW'(e.idx));
        check("wr_index_valid", VW'(d_v), VW'(1));
      end else if (s_arb != '0) begin
        check("unexpected_wr", VW'(s_arb), '0);
      end
    end
  end

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_req(input logic [IW-1:0] idx, input logic [NM-1:0] m,
                           input logic [DW-1:0] w);
    logic [VW-1:0] d, nxt;
    for (int b = 0; b < NM; b++) d[b*DW +: DW] = w;
    nxt = ref_tbl[idx];
    for (int b = 0; b < NM; b++)
      if (m[b]) nxt[b*DW +: DW] = nxt[b*DW +: DW] ^ d[b*DW +: DW];
    ref_tbl[idx] = nxt;
    check("req_ready", VW'(req_ready), VW'(1));
    req_valid = 1'b1;
    req_index = idx;
    req_mask  = m;
    req_data  = d;
    sb.push_back('{cyc + DATA_LAT, idx, m, nxt});
    @(negedge clk);
  endtask

  // Assert reset for one edge, check reset values, release and follow the sweep.
  task automatic reset_and_sweep();
    int r;
    req_valid = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    sb.delete();
    @(negedge clk);
    check("rst_req_ready", VW'(req_ready), '0);
    check("rst_init_done", VW'(init_done), '0);
    check("rst_wr0_valid", VW'(write_reg_0_valid), '0);
    check("rst_wr0_index", VW'(write_reg_0_index), '0);
    check("rst_arbiter", VW'(arbiter_result), '0);
    check("rst_rd_index", VW'(rd_index), '0);
    check("rst_xor", write_reg_11_xor, '0);
    reset = 1'b1;
    r = cyc;
    for (int k = 0; k < NIDX; k++) begin
      sb.push_back('{r + k + DATA_LAT, IW'(k), '1, '0});
      ref_tbl[k] = '0;
    end
    for (int k = 0; k < NIDX; k++) begin
      check("init_req_ready", VW'(req_ready), '0);
      check("init_done_low", VW'(init_done), '0);
      @(negedge clk);
    end
    check("run_req_ready", VW'(req_ready), VW'(1));
    check("init_done_high", VW'(init_done), VW'(1));
    idle(10);
    for (int k = 0; k < NIDX; k++) check("sweep_zero", tbl[k], '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Non-zero power-up contents show that the sweep really overwrites them.
    for (int k = 0; k < NIDX; k++) begin
      tbl[k]     = {NM{64'hA5A5_0000_0000_0000 + 64'(k)}};
      ref_tbl[k] = '0;
    end
    repeat (2) @(negedge clk);

    // 1: reset release and zero sweep
    reset_and_sweep();

    // 2: single partial-mask request
    drive_req(4'd3, 4'b0101, 64'h11);
    idle(10);
    check("t2_word", tbl[3], {64'h0, 64'h11, 64'h0, 64'h11});

    // 3: eight back-to-back requests to one index
    for (int k = 0; k < 8; k++) drive_req(4'd5, 4'hF, 64'd1 << k);
    idle(10);
    check("t3_word", tbl[5], {NM{64'hFF}});

    // 4: per-bank youngest-match selection
    drive_req(4'd7, 4'b0001, 64'hA);
    drive_req(4'd7, 4'b0010, 64'hB);
    drive_req(4'd7, 4'hF, 64'h1);
    idle(10);
    check("t4_word", tbl[7], {64'h1, 64'h1, 64'hA, 64'hB});

    // 5: gap of 6 (just outside the window) and gap of 5 (oldest forwarded age)
    drive_req(4'd9, 4'hF, 64'h3);
    idle(6);
    drive_req(4'd9, 4'hF, 64'h5);
    idle(10);
    check("t5_gap6_word", tbl[9], {NM{64'h6}});
    drive_req(4'd10, 4'hF, 64'h30);
    idle(5);
    drive_req(4'd10, 4'b0110, 64'h0C);
    idle(10);
    check("t5_gap5_word", tbl[10], {64'h30, 64'h3C, 64'h3C, 64'h30});

    for (int k = 0; k < NIDX; k++) check("table_vs_ref", tbl[k], ref_tbl[k]);

    // 6: reset in the middle of a burst
    drive_req(4'd2, 4'hF, 64'h10);
    drive_req(4'd2, 4'hF, 64'h20);
    drive_req(4'd11, 4'b1001, 64'h30);
    reset_and_sweep();
    drive_req(4'd2, 4'b1000, 64'h77);
    idle(10);
    check("t6_post_word", tbl[2], {64'h77, 64'h0, 64'h0, 64'h0});
    check("sb_drained", VW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
